// File: rtl/if_fetch_pkg.sv
// Shared widths, encodings and the fetch FSM state type for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned INST_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  // States in which a memory request is on the bus.
  function automatic logic req_active(input fetch_state_t s);
    return (s == S_REQ) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/if_fetch_id_reg.sv
// IF/ID pipeline register: load has priority over bubble; otherwise contents are held.
module if_id_reg #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INST_W   = 16,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  // Select next IF/ID contents; a bubble keeps the PC so ID sees a stable id_pc.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (load_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end else if (bubble_i) begin
      inst_d  = NOP_INST;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_q;
      inst_d  = inst_q;
      valid_d = valid_q;
    end
  end

  // IF/ID state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q    <= {ADDR_W{1'b0}};
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign id_pc_o    = pc_q;
  assign id_inst_o  = inst_q;
  assign id_valid_o = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, req/ack memory handshake, one-entry skid buffer and redirect handling,
// feeding the IF/ID register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [ADDR_W-1:0] pc_inc;

  logic              ifid_load;
  logic              ifid_bubble;
  logic [ADDR_W-1:0] ifid_pc;
  logic [INST_W-1:0] ifid_inst;

  assign pc_inc = pc_q + ADDR_W'(1);

  // Next-state, PC, request address and IF/ID controls; a redirect outranks stall and ack everywhere.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_pc     = pc_q;
    ifid_inst   = imem_rdata;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (branch_flag_i) begin
          pc_d        = branch_target_i;
          addr_d      = branch_target_i;
          ifid_bubble = 1'b1;
        end else begin
          addr_d      = pc_q;
          ifid_bubble = !stall_i;
        end
      end

      S_REQ: begin
        if (branch_flag_i) begin
          pc_d        = branch_target_i;
          ifid_bubble = 1'b1;
          // Without ack the old address must stay on the bus until memory answers.
          if (imem_ack) begin
            addr_d = branch_target_i;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d   = pc_inc;
          addr_d = pc_inc;
          if (stall_i) begin
            skid_pc_d   = pc_q;
            skid_inst_d = imem_rdata;
            state_d     = S_HOLD;
          end else begin
            ifid_load = 1'b1;
          end
        end else begin
          ifid_bubble = !stall_i;
        end
      end

      S_HOLD: begin
        if (branch_flag_i) begin
          pc_d        = branch_target_i;
          addr_d      = branch_target_i;
          ifid_bubble = 1'b1;
          state_d     = S_REQ;
        end else if (!stall_i) begin
          ifid_load = 1'b1;
          ifid_pc   = skid_pc_q;
          ifid_inst = skid_inst_q;
          addr_d    = pc_q;
          state_d   = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end

      S_DRAIN: begin
        if (branch_flag_i) begin
          pc_d        = branch_target_i;
          ifid_bubble = 1'b1;
        end else if (imem_ack) begin
          addr_d      = pc_q;
          ifid_bubble = !stall_i;
          state_d     = S_REQ;
        end else begin
          ifid_bubble = !stall_i;
        end
      end

      default: begin
        state_d     = S_IDLE;
        pc_d        = RESET_PC;
        addr_d      = RESET_PC;
        ifid_bubble = 1'b1;
      end
    endcase

    req_d = req_active(state_d);
  end

  // Fetch-side state; imem_req/imem_addr come straight from flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      skid_pc_q   <= {ADDR_W{1'b0}};
      skid_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .NOP_INST(NOP_INST)
  ) u_if_id_reg (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (ifid_load),
    .bubble_i  (ifid_bubble),
    .pc_i      (ifid_pc),
    .inst_i    (ifid_inst),
    .id_pc_o   (id_pc),
    .id_inst_o (id_inst),
    .id_valid_o(id_valid)
  );

endmodule
